// File: rtl/fifo_reader_pkg.sv
// ============================================================================
// Module  : fifo_reader_pkg
// Purpose : State encoding and data widths shared by the fifo_reader block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_reader_pkg;

    localparam int c_WORD_W = 16;
    localparam int c_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_reader.sv
// ============================================================================
// Module  : fifo_reader
// Purpose : Pops a programmed number of 16-bit FIFO words and streams each as
//           two bytes (high first) on a valid/ready byte link.
//           Optional empty-wait abort: define FIFO_READER_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int LEN_W = 8
`ifdef FIFO_READER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                fifo_rd,
    input  logic [c_WORD_W-1:0] fifo_dout,
    input  logic                fifo_empty,
    output logic [c_BYTE_W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [LEN_W-1:0]    words_rd,
    output logic                err
);

    state_t              state_q, state_d;
    logic [c_WORD_W-1:0] word_q, word_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [LEN_W-1:0]    words_q, words_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                w_accept;
    logic                w_pop;
    logic                w_timeout;

    assign w_accept = (state_q == ST_IDLE) && start;

`ifdef FIFO_READER_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1; the next empty cycle aborts.
    localparam int                  c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_WAIT_W-1:0] wait_q, wait_d;
    logic                err_q, err_d;

    assign w_timeout = (state_q == ST_FETCH) && fifo_empty && (wait_q == c_WAIT_LAST);

    always_comb begin
        wait_d = '0;
        if ((state_q == ST_FETCH) && fifo_empty && !w_timeout) begin
            wait_d = wait_q + c_WAIT_W'(1);
        end
        err_d = err_q;
        if (w_accept) begin
            err_d = 1'b0;
        end else if (w_timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rem_d   = rem_q;
        words_d = words_q;
        w_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    words_d = '0;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = len;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    w_pop = 1'b1;
                end else if (w_timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_HI: begin
                if (m_ready) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                // Prefetch on the low-byte handshake keeps full rate at 2 cycles/word.
                if (m_ready) begin
                    if (rem_q == '0) begin
                        state_d = ST_DONE;
                    end else if (!fifo_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_pop) begin
            word_d  = fifo_dout;
            rem_d   = rem_q - LEN_W'(1);
            words_d = words_q + LEN_W'(1);
            state_d = ST_HI;
        end

        busy_d = (state_d == ST_FETCH) || (state_d == ST_HI) || (state_d == ST_LO);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            rem_q   <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd  = w_pop;
    assign m_valid  = (state_q == ST_HI) || (state_q == ST_LO);
    assign m_data   = (state_q == ST_HI) ? word_q[c_WORD_W-1:c_BYTE_W] :
                      (state_q == ST_LO) ? word_q[c_BYTE_W-1:0]        : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign words_rd = words_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_reader.sv
// ============================================================================
// Module  : tb_fifo_reader
// Purpose : Directed self-checking bench for fifo_reader with a FIFO model and
//           an expected-byte scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        fifo_rd;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  words_rd;
    logic        err;

    always #5 clk = ~clk;

    fifo_reader #(
        .LEN_W   (8)
`ifdef FIFO_READER_TIMEOUT_EN
        ,
        .TIMEOUT (4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .words_rd   (words_rd),
        .err        (err)
    );

    logic [15:0] fifo_mem[$];
    logic [7:0]  exp_q[$];
    bit          force_empty;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_rd     = 0;
    int n_hs     = 0;
    int n_rd_hs  = 0;
    int n_done   = 0;
    int first_hs = -1;
    int last_hs  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = force_empty || (fifo_mem.size() == 0);
        fifo_dout  = (fifo_mem.size() != 0) ? fifo_mem[0] : 16'h0000;
    endtask

    task automatic load(input logic [15:0] w, input bit expect_out);
        fifo_mem.push_back(w);
        if (expect_out) begin
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        drive_fifo();
    endtask

    // One clock: sample at the falling edge, then apply FIFO pops after the rise.
    task automatic cycle();
        logic       pop;
        logic       hs;
        logic [7:0] d;
        @(negedge clk);
        pop = fifo_rd;
        hs  = m_valid && m_ready;
        d   = m_data;
        chk("rd_while_empty", fifo_rd && fifo_empty, 1'b0);
        chk("data_nonzero_idle", (!m_valid && (m_data != 8'h00)), 1'b0);
        if (hs) begin
            n_hs++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_byte observed=0x%0h expected=none", d);
            end
            if (exp_q.size() != 0) chk("byte", d, exp_q.pop_front());
            if (pop) n_rd_hs++;
        end
        if (pop) n_rd++;
        if (done) n_done++;
        @(posedge clk);
        #1;
        cyc++;
        if (pop && fifo_mem.size() != 0) void'(fifo_mem.pop_front());
        drive_fifo();
    endtask

    task automatic run_until_done(input int max_cyc, input string tag);
        int d0;
        int k;
        d0 = n_done;
        k  = 0;
        while (n_done == d0 && k < max_cyc) begin
            cycle();
            k++;
        end
        chk({tag, "_done_seen"}, (n_done != d0), 1'b1);
        chk({tag, "_done_width"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int rd0;
        int hs0;
        int rdhs0;
        int k;

        rst         = 1'b0;
        start       = 1'b0;
        len         = 8'd0;
        m_ready     = 1'b0;
        force_empty = 1'b0;
        drive_fifo();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_words_rd", words_rd, 8'h00);
        chk("rst_err", err, 1'b0);
        rst = 1'b1;
        cycle();

        // Full-rate two-word transfer with a dropped start while busy.
        m_ready = 1'b1;
        load(16'h1234, 1'b1);
        load(16'hABCD, 1'b1);
        rd0 = n_rd; hs0 = n_hs; rdhs0 = n_rd_hs; first_hs = -1;
        start = 1'b1; len = 8'd2;
        cycle();
        start = 1'b0;
        chk("fr_busy", busy, 1'b1);
        cycle();
        start = 1'b1; len = 8'd5;
        cycle();
        start = 1'b0;
        run_until_done(20, "fr");
        chk("fr_rd_count", n_rd - rd0, 2);
        chk("fr_byte_count", n_hs - hs0, 4);
        chk("fr_consecutive", last_hs - first_hs, 3);
        chk("fr_prefetch_rd", n_rd_hs - rdhs0, 1);
        chk("fr_words_rd", words_rd, 8'd2);
        chk("fr_err", err, 1'b0);

        // Backpressure on the high byte.
        m_ready = 1'b0;
        load(16'h5AA5, 1'b1);
        hs0 = n_hs;
        start = 1'b1; len = 8'd1;
        cycle();
        start = 1'b0;
        k = 0;
        while (!m_valid && k < 10) begin
            cycle();
            k++;
        end
        chk("bp_reach_hi", m_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", m_valid, 1'b1);
            chk("bp_data_held", m_data, 8'h5A);
            cycle();
        end
        chk("bp_no_hs", n_hs - hs0, 0);
        m_ready = 1'b1;
        run_until_done(20, "bp");
        chk("bp_byte_count", n_hs - hs0, 2);

        // Empty stall then release.
        force_empty = 1'b1;
        load(16'h00FF, 1'b1);
        rd0 = n_rd;
        start = 1'b1; len = 8'd1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("es_busy", busy, 1'b1);
            chk("es_no_rd", fifo_rd, 1'b0);
            cycle();
        end
        force_empty = 1'b0;
        drive_fifo();
        run_until_done(20, "es");
        chk("es_rd_count", n_rd - rd0, 1);
        chk("es_words_rd", words_rd, 8'd1);

        // Zero-length command completes without touching the FIFO.
        load(16'hBEEF, 1'b0);
        rd0 = n_rd; hs0 = n_hs;
        start = 1'b1; len = 8'd0;
        cycle();
        start = 1'b0;
        chk("z_done", done, 1'b1);
        chk("z_busy", busy, 1'b0);
        cycle();
        chk("z_done_width", done, 1'b0);
        chk("z_no_rd", n_rd - rd0, 0);
        chk("z_no_byte", n_hs - hs0, 0);
        chk("z_words_rd", words_rd, 8'd0);
        fifo_mem.delete();
        drive_fifo();

        // Asynchronous reset while a byte is being offered.
        m_ready = 1'b0;
        load(16'h1111, 1'b0);
        load(16'h2222, 1'b0);
        start = 1'b1; len = 8'd2;
        cycle();
        start = 1'b0;
        k = 0;
        while (!m_valid && k < 10) begin
            cycle();
            k++;
        end
        chk("rm_reach_hi", m_valid, 1'b1);
        chk("rm_words_before", words_rd, 8'd1);
        rst = 1'b0;
        #1;
        chk("rm_valid", m_valid, 1'b0);
        chk("rm_busy", busy, 1'b0);
        chk("rm_data", m_data, 8'h00);
        chk("rm_words", words_rd, 8'd0);
        rd0 = n_rd;
        cycle();
        rst = 1'b1;
        repeat (3) cycle();
        chk("rm_no_rd_after", n_rd - rd0, 0);
        chk("rm_idle_busy", busy, 1'b0);
        fifo_mem.delete();
        drive_fifo();
        m_ready = 1'b1;

`ifdef FIFO_READER_TIMEOUT_EN
        // One word then a dry FIFO: abort after four empty waits.
        load(16'hC3E1, 1'b1);
        hs0 = n_hs;
        start = 1'b1; len = 8'd3;
        cycle();
        start = 1'b0;
        run_until_done(30, "to");
        chk("to_err", err, 1'b1);
        chk("to_words_rd", words_rd, 8'd1);
        chk("to_byte_count", n_hs - hs0, 2);
        start = 1'b1; len = 8'd0;
        cycle();
        start = 1'b0;
        chk("to_err_cleared", err, 1'b0);
        cycle();
`else
        chk("no_to_err", err, 1'b0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
